// File: rtl/fft_seq_engine.sv
// fft_seq_engine: iterative radix-2 DIT complex FFT, one butterfly stage per clock, scaled by 1/SAMPLES.
// Define FFT_INVERSE_EN to add the 'inverse' port (conjugated twiddles, IDFT/SAMPLES).
module fft_seq_engine #(
  parameter int WIDTH    = 16,
  parameter int SAMPLES  = 8,
  parameter int TW_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SAMPLES-1:0][WIDTH-1:0] in_re,
  input  logic [SAMPLES-1:0][WIDTH-1:0] in_im,
`ifdef FFT_INVERSE_EN
  input  logic                          inverse,
`endif
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SAMPLES-1:0][WIDTH-1:0] out_re,
  output logic [SAMPLES-1:0][WIDTH-1:0] out_im,
  output logic                          busy,
  output logic [$clog2(SAMPLES)-1:0]    stage
);
  localparam int  L        = $clog2(SAMPLES);
  localparam int  AW       = WIDTH + 2;
  localparam int  PW       = WIDTH + TW_WIDTH + 2;
  localparam real PI       = 3.14159265358979323846;
  localparam real TW_SCALE = 2.0 ** (TW_WIDTH - 1);
  localparam int  TW_MAX   = (1 << (TW_WIDTH - 1)) - 1;
  localparam logic signed [PW-1:0] TW_RND  = PW'(1) << (TW_WIDTH - 2);
  localparam logic signed [AW-1:0] SAT_MAX = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {3'b111, {(WIDTH-1){1'b0}}};

  if (SAMPLES < 2 || (SAMPLES & (SAMPLES - 1)) != 0) begin : g_bad_samples
    $error("fft_seq_engine: SAMPLES must be a power of two >= 2");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                        state_q, state_d;
  logic [L-1:0]                  stage_q, stage_d;
  logic                          inv_q, inv_d, inv_in_s;
  logic [SAMPLES-1:0][WIDTH-1:0] re_q, re_d, im_q, im_d;
  logic [SAMPLES-1:0][WIDTH-1:0] cap_re_s, cap_im_s, bf_re_s, bf_im_s;
  logic signed [TW_WIDTH-1:0]    tw_re_s [SAMPLES];
  logic signed [TW_WIDTH-1:0]    tw_im_s [SAMPLES];

  function automatic logic [L-1:0] bitrev(input logic [L-1:0] v);
    logic [L-1:0] r;
    r = '0;
    for (int b = 0; b < L; b++) r[b] = v[L-1-b];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] sat(input logic signed [AW-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[WIDTH-1:0];
    else if (v < SAT_MIN) return SAT_MIN[WIDTH-1:0];
    else                  return v[WIDTH-1:0];
  endfunction

  // Twiddle ROM tw[m] = cos - j*sin, rounded to nearest; +1.0 cannot be represented and is clamped.
  for (genvar m = 0; m < SAMPLES; m++) begin : g_tw
    localparam real RC = $cos(2.0 * PI * m / SAMPLES) * TW_SCALE;
    localparam real RS = -$sin(2.0 * PI * m / SAMPLES) * TW_SCALE;
    localparam int  IC = (RC >= 0.0) ? $rtoi(RC + 0.5) : -$rtoi(0.5 - RC);
    localparam int  IS = (RS >= 0.0) ? $rtoi(RS + 0.5) : -$rtoi(0.5 - RS);
    assign tw_re_s[m] = TW_WIDTH'((IC > TW_MAX) ? TW_MAX : IC);
    assign tw_im_s[m] = TW_WIDTH'((IS > TW_MAX) ? TW_MAX : IS);
  end

`ifdef FFT_INVERSE_EN
  assign inv_in_s = inverse;
`else
  assign inv_in_s = 1'b0;
`endif

  // Frame capture in bit-reversed order.
  always_comb begin
    cap_re_s = '0;
    cap_im_s = '0;
    for (int i = 0; i < SAMPLES; i++) begin
      cap_re_s[bitrev(L'(i))] = in_re[L'(i)];
      cap_im_s[bitrev(L'(i))] = in_im[L'(i)];
    end
  end

  // All SAMPLES/2 butterflies of the current stage; pair index p gets a zero inserted at bit 'stage'.
  always_comb begin : bf_stage
    logic [L-1:0]         mask, pv, ia, ib, tk;
    logic signed [PW-1:0] br, bi, wr, wi, pr, pim;
    logic signed [AW-1:0] ar, ai, tr, ti;
    bf_re_s = re_q;
    bf_im_s = im_q;
    mask = (L'(1) << stage_q) - L'(1);
    pv = '0; ia = '0; ib = '0; tk = '0;
    br = '0; bi = '0; wr = '0; wi = '0; pr = '0; pim = '0;
    ar = '0; ai = '0; tr = '0; ti = '0;
    for (int p = 0; p < SAMPLES / 2; p++) begin
      pv = L'(p);
      ia = ((pv & ~mask) << 1) | (pv & mask);
      ib = ia | (L'(1) << stage_q);
      tk = (pv & mask) << (L'(L - 1) - stage_q);
      br = PW'($signed(re_q[ib]));
      bi = PW'($signed(im_q[ib]));
      wr = PW'(tw_re_s[tk]);
      wi = inv_q ? -PW'(tw_im_s[tk]) : PW'(tw_im_s[tk]);
      pr  = br * wr - bi * wi + TW_RND;
      pim = br * wi + bi * wr + TW_RND;
      tr = AW'(pr >>> (TW_WIDTH - 1));
      ti = AW'(pim >>> (TW_WIDTH - 1));
      ar = AW'($signed(re_q[ia]));
      ai = AW'($signed(im_q[ia]));
      bf_re_s[ia] = sat((ar + tr) >>> 1);
      bf_im_s[ia] = sat((ai + ti) >>> 1);
      bf_re_s[ib] = sat((ar - tr) >>> 1);
      bf_im_s[ib] = sat((ai - ti) >>> 1);
    end
  end

  // Control FSM next state and work-register update.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    inv_d   = inv_q;
    re_d    = re_q;
    im_d    = im_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          re_d    = cap_re_s;
          im_d    = cap_im_s;
          inv_d   = inv_in_s;
          stage_d = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        re_d = bf_re_s;
        im_d = bf_im_s;
        if (stage_q == L'(L - 1)) begin
          stage_d = '0;
          state_d = DONE;
        end else begin
          stage_d = stage_q + L'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
        else           state_d = DONE;
      end
      default: begin
        state_d = IDLE;
        stage_d = '0;
      end
    endcase
  end

  // State and work registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      stage_q <= '0;
      inv_q   <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      inv_q   <= inv_d;
      re_q    <= re_d;
      im_q    <= im_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign stage     = stage_q;
  assign out_re    = re_q;
  assign out_im    = im_q;
endmodule

// File: tb/tb_fft_seq_engine.sv
// Self-checking bench for fft_seq_engine: a real-valued DFT/N model fills a scoreboard
// that is drained and compared (with a per-frame LSB tolerance) when the DUT presents results.
module tb_fft_seq_engine;
  localparam int  WIDTH    = 16;
  localparam int  SAMPLES  = 8;
  localparam int  TW_WIDTH = 16;
  localparam int  LB       = $clog2(SAMPLES);
  localparam real PI       = 3.14159265358979323846;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          in_valid, in_ready, out_valid, out_ready, busy, inv_s;
  logic [SAMPLES-1:0][WIDTH-1:0] in_re, in_im, out_re, out_im;
  logic [LB-1:0]                 stage;

  int vectors = 0;
  int errors  = 0;
  int exp_re_q[$];
  int exp_im_q[$];
  int tol_q[$];

  fft_seq_engine #(.WIDTH(WIDTH), .SAMPLES(SAMPLES), .TW_WIDTH(TW_WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
`ifdef FFT_INVERSE_EN
    .inverse(inv_s),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .busy(busy), .stage(stage)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

  function automatic int rnd_clamp(input real v);
    int r;
    r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  // Reference: X[k] = (1/N) * sum x[n] * exp(-/+ j*2*pi*k*n/N), pushed to the scoreboard.
  task automatic model_push(input int xr[SAMPLES], input int xi[SAMPLES], input bit inv, input int tol);
    real sr, si, ang, sg;
    sg = inv ? 1.0 : -1.0;
    for (int k = 0; k < SAMPLES; k++) begin
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < SAMPLES; n++) begin
        ang = 2.0 * PI * real'(k * n) / real'(SAMPLES);
        sr += real'(xr[n]) * $cos(ang) - sg * real'(xi[n]) * $sin(ang);
        si += real'(xi[n]) * $cos(ang) + sg * real'(xr[n]) * $sin(ang);
      end
      exp_re_q.push_back(rnd_clamp(sr / real'(SAMPLES)));
      exp_im_q.push_back(rnd_clamp(si / real'(SAMPLES)));
    end
    tol_q.push_back(tol);
  endtask

  task automatic drive_frame(input int xr[SAMPLES], input int xi[SAMPLES]);
    for (int i = 0; i < SAMPLES; i++) begin
      in_re[i] = WIDTH'(xr[i]);
      in_im[i] = WIDTH'(xi[i]);
    end
  endtask

  // One full frame: accept, latency, every bin against the scoreboard, release.
  task automatic test_frame(input string name, input int xr[SAMPLES], input int xi[SAMPLES],
                            input bit inv, input int tol);
    int cyc, er, ei, ar, ai, t;
    model_push(xr, xi, inv, tol);
    drive_frame(xr, xi);
    inv_s = inv;
    in_valid = 1'b1;
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: in_ready=%b required 1", name, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    vectors++;
    if (cyc != LB) begin
      errors++;
      $display("FAIL %s latency: out_valid after %0d cycles, required %0d", name, cyc, LB);
    end
    t = tol_q.pop_front();
    for (int k = 0; k < SAMPLES; k++) begin
      er = exp_re_q.pop_front();
      ei = exp_im_q.pop_front();
      ar = $signed(out_re[k]);
      ai = $signed(out_im[k]);
      vectors++;
      if (ar > er + t || ar < er - t) begin
        errors++;
        $display("FAIL %s re[%0d]: got %0d required %0d +/-%0d", name, k, ar, er, t);
      end
      vectors++;
      if (ai > ei + t || ai < ei - t) begin
        errors++;
        $display("FAIL %s im[%0d]: got %0d required %0d +/-%0d", name, k, ai, ei, t);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release: out_valid=%b in_ready=%b required 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset flags: in_ready=%b busy=%b out_valid=%b required 1/0/0", in_ready, busy, out_valid);
    end
    vectors++;
    if (stage !== '0) begin
      errors++;
      $display("FAIL reset stage: got %0d required 0", stage);
    end
    vectors++;
    if (out_re !== '0 || out_im !== '0) begin
      errors++;
      $display("FAIL reset outputs: got re=%h im=%h required 0", out_re, out_im);
    end
  endtask

  task automatic test_impulse();
    int xr[SAMPLES], xi[SAMPLES];
    for (int i = 0; i < SAMPLES; i++) begin xr[i] = 0; xi[i] = 0; end
    xr[0] = 1000;
    test_frame("impulse", xr, xi, 1'b0, 0);
  endtask

  task automatic test_dc();
    int xr[SAMPLES], xi[SAMPLES];
    for (int i = 0; i < SAMPLES; i++) begin xr[i] = 800; xi[i] = 0; end
    test_frame("dc", xr, xi, 1'b0, 1);
  endtask

  task automatic test_nyquist();
    int xr[SAMPLES], xi[SAMPLES];
    for (int i = 0; i < SAMPLES; i++) begin xr[i] = (i % 2 == 0) ? 800 : -800; xi[i] = 0; end
    test_frame("nyquist", xr, xi, 1'b0, 1);
  endtask

  task automatic test_random();
    int xr[SAMPLES], xi[SAMPLES];
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < SAMPLES; i++) begin
        xr[i] = int'($urandom_range(8000)) - 4000;
        xi[i] = int'($urandom_range(8000)) - 4000;
      end
      test_frame("random", xr, xi, 1'b0, 3);
    end
  endtask

  task automatic test_saturation();
    int xr[SAMPLES], xi[SAMPLES];
    for (int i = 0; i < SAMPLES; i++) begin xr[i] = 32767; xi[i] = -32768; end
    test_frame("saturation", xr, xi, 1'b0, 4);
  endtask

  task automatic test_back_pressure();
    int cyc;
    bit ok;
    for (int i = 0; i < SAMPLES; i++) begin in_re[i] = '0; in_im[i] = '0; end
    in_re[0] = 16'd1000;
    inv_s = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0];
      ok = 1'b1;
      for (int k = 0; k < SAMPLES; k++) begin
        if ($signed(out_re[k]) != 125 || $signed(out_im[k]) != 0) ok = 1'b0;
      end
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL backpressure flags c%0d: out_valid=%b in_ready=%b busy=%b required 1/0/0",
                 c, out_valid, in_ready, busy);
      end
      vectors++;
      if (!ok) begin
        errors++;
        $display("FAIL backpressure data c%0d: got re=%h im=%h required 125s/0s", c, out_re, out_im);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL backpressure no-accept: busy=%b required 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int xr[SAMPLES], xi[SAMPLES];
    int acc, got, cyc, t, er, ei, ar, ai;
    int acc_cyc[2];
    acc = 0; got = 0; acc_cyc[0] = 0; acc_cyc[1] = 0;
    for (int i = 0; i < SAMPLES; i++) begin
      xr[i] = int'($urandom_range(6000)) - 3000;
      xi[i] = int'($urandom_range(6000)) - 3000;
    end
    model_push(xr, xi, 1'b0, 3);
    model_push(xr, xi, 1'b0, 3);
    drive_frame(xr, xi);
    inv_s = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (cyc = 0; cyc < 40 && got < 2; cyc++) begin
      if (acc == 2) in_valid = 1'b0;
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        acc_cyc[acc] = cyc;
        acc++;
      end
      if (out_valid === 1'b1 && tol_q.size() > 0) begin
        t = tol_q.pop_front();
        for (int k = 0; k < SAMPLES; k++) begin
          er = exp_re_q.pop_front();
          ei = exp_im_q.pop_front();
          ar = $signed(out_re[k]);
          ai = $signed(out_im[k]);
          vectors++;
          if (ar > er + t || ar < er - t || ai > ei + t || ai < ei - t) begin
            errors++;
            $display("FAIL b2b frame%0d bin%0d: got %0d/%0d required %0d/%0d +/-%0d", got, k, ar, ai, er, ei, t);
          end
        end
        got++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    exp_re_q.delete(); exp_im_q.delete(); tol_q.delete();
    vectors++;
    if (got != 2) begin
      errors++;
      $display("FAIL b2b frames: got %0d results required 2", got);
    end
    vectors++;
    if (acc_cyc[1] - acc_cyc[0] != LB + 2) begin
      errors++;
      $display("FAIL b2b period: got %0d cycles required %0d", acc_cyc[1] - acc_cyc[0], LB + 2);
    end
  endtask

  task automatic test_reset_mid_run();
    int xr[SAMPLES], xi[SAMPLES];
    int cyc;
    for (int i = 0; i < SAMPLES; i++) begin
      xr[i] = int'($urandom_range(4000)) - 2000;
      xi[i] = int'($urandom_range(4000)) - 2000;
    end
    drive_frame(xr, xi);
    inv_s = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (stage !== LB'(1) && cyc < 10) begin @(posedge clk); #1; cyc++; end
    vectors++;
    if (stage !== LB'(1) || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun reach: stage=%0d busy=%b required 1/1", stage, busy);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || stage !== '0) begin
      errors++;
      $display("FAIL midrun reset flags: out_valid=%b busy=%b in_ready=%b stage=%0d required 0/0/1/0",
               out_valid, busy, in_ready, stage);
    end
    vectors++;
    if (out_re !== '0 || out_im !== '0) begin
      errors++;
      $display("FAIL midrun reset outputs: got re=%h im=%h required 0", out_re, out_im);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    test_impulse();
  endtask

`ifdef FFT_INVERSE_EN
  task automatic test_inverse();
    int xr[SAMPLES], xi[SAMPLES];
    for (int i = 0; i < SAMPLES; i++) begin xr[i] = 0; xi[i] = 0; end
    xr[0] = 800;
    test_frame("inverse_dc", xr, xi, 1'b1, 0);
    for (int i = 0; i < SAMPLES; i++) begin
      xr[i] = int'($urandom_range(6000)) - 3000;
      xi[i] = int'($urandom_range(6000)) - 3000;
    end
    test_frame("inverse_random", xr, xi, 1'b1, 3);
  endtask
`endif

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    inv_s = 1'b0;
    in_re = '0;
    in_im = '0;
    test_reset();
    test_impulse();
    test_dc();
    test_nyquist();
    test_random();
    test_saturation();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid_run();
`ifdef FFT_INVERSE_EN
    test_inverse();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/fft_seq_engine.md
Name: fft_seq_engine

Overview:
- Parametrised, iterative radix-2 decimation-in-time complex FFT.
- Accepts one frame of SAMPLES complex points through a valid/ready handshake and bit-reverses it on capture.
- Runs one full butterfly stage per clock, log2(SAMPLES) stages in total, then holds the result until the consumer takes it.
- Successor to the fixed-size sequential FFT step: adds complex I/O, twiddle ROM, per-stage scaling with saturation, handshakes and inverse mode.

Parameters:
- WIDTH, 16: bits per real/imag component, two's complement.
- SAMPLES, 8: FFT size; power of two, at least 2; anything else is an elaboration error.
- TW_WIDTH, 16: twiddle component width, Q1.(TW_WIDTH-1) signed.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous and active-high.
- in_valid  in  1  input frame present.
- in_ready  out  1  block can accept a frame.
- in_re  in  [WIDTH-1:0] x SAMPLES  input real parts, natural order.
- in_im  in  [WIDTH-1:0] x SAMPLES  input imaginary parts, natural order.
- out_valid  out  1  result frame present.
- out_ready  in  1  consumer takes the result.
- out_re  out  [WIDTH-1:0] x SAMPLES  result real parts, natural bin order.
- out_im  out  [WIDTH-1:0] x SAMPLES  result imaginary parts, natural bin order.
- busy  out  1  high in RUN.
- stage  out  [$clog2(SAMPLES)-1:0]  current stage index (0 outside RUN).

Behaviour:
- Definitions: L = $clog2(SAMPLES).
- State register values: IDLE=0, RUN=1, DONE=2.
- Reset (asynchronous, any state, including mid-frame):
  - state=IDLE, stage=0.
  - All work registers = 0, so out_re/out_im = 0.
  - out_valid=0, busy=0, in_ready=1.
  - Any in-flight frame is discarded.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&&in_ready: work[bitrev(i)] <= in[i] for all i; stage<=0; go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each edge applies stage s to all SAMPLES/2 butterflies, then s<=s+1.
  - On the edge that completes s=L-1: go to DONE, stage<=0.
- DONE:
  - out_valid=1, in_ready=0.
  - out_re/out_im come directly from the work registers and are stable while out_ready=0.
  - On an edge with out_ready=1: go to IDLE.
  - A new frame is accepted no earlier than the following IDLE cycle.
- Latency and throughput:
  - out_valid rises exactly L cycles after the accept edge.
  - Minimum frame period is L+2 cycles.
- Butterfly for stage s:
  - half=2^s; pairs (i, i+half), with i taken in groups of 2*half, k=i mod (2*half), k<half.
  - Twiddle W=tw[k*SAMPLES/(2*half)], where tw[m] = cos(2*pi*m/N) - j*sin(2*pi*m/N).
  - Twiddles are computed at elaboration, rounded to nearest, and +1.0 is clamped to 2^(TW_WIDTH-1)-1.
  - t = b*W, full-precision complex multiply: t component = (sum + 2^(TW_WIDTH-2)) >>> (TW_WIDTH-1).
  - y0 = (a+t)>>>1 and y1 = (a-t)>>>1, computed at WIDTH+2 bits, then saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Net output is DFT/SAMPLES.
- Out-of-range handshake inputs: in_valid held in RUN or DONE has no effect. out_ready outside DONE has no effect.

Optional Feature:
- Macro: FFT_INVERSE_EN.
- Defined:
  - Adds input port inverse (1 bit), sampled on the accept edge and held for the whole frame.
  - inverse=1 uses conjugated twiddles (+j*sin), producing IDFT/SAMPLES with the same scaling, latency and saturation.
- Undefined: no inverse port; forward transform only.

Test Plan:
- Impulse (SAMPLES=8, WIDTH=16): in_re[0]=1000, all other inputs 0 -> every out_re=125, every out_im=0. out_valid rises 3 cycles after the accept edge.
- DC: all in_re=800 -> out_re[0]=800; all other bins re=im=0 within ±1 LSB.
- Nyquist: in_re[n]=+800 for even n and -800 for odd n -> out_re[4]=800; all other bins within ±1 LSB of 0.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid -> out_valid stays 1, outputs are unchanged, in_ready=0, no frame is accepted. Release -> IDLE next cycle, in_ready=1.
- Reset mid-run: assert rst while stage=1 -> immediately out_valid=0, busy=0, in_ready=1, outputs 0. A following impulse frame gives correct results.
- Saturation: all in_re=32767, in_im=-32768 -> out_re[0]=32767, out_im[0]=-32768, no wrap. With FFT_INVERSE_EN and inverse=1, X[0]=800 gives every out_re=100.
